mfcc_seg_ctrl: RTL and testbench

Utterance segmentation controller that sequences the MFCC averaging datapath. It watches a per-frame voice-activity flag and drives the averager's segment gate (`data_valid`) with onset qualification and hangover. It then collects the 13-coefficient mean burst, tags each coefficient with its index, and hands the segment to the downstream matcher over a ready/done handshake. It sits between the VAD/framing logic and the averager/template-matching stage.

---
 rtl/mfcc_seg_ctrl.sv | 117 +++++++++++
 tb/tb_mfcc_seg_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mfcc_seg_ctrl.sv
// mfcc_seg_ctrl: gates the MFCC averager per utterance (onset/hangover) and hands the mean burst to the matcher
module mfcc_seg_ctrl #(
   parameter int ONSET_FRAMES = 3,
   parameter int HANG_FRAMES  = 8,
   parameter int MIN_FRAMES   = 20,
   parameter int MAX_FRAMES   = 1000,
   parameter int NCOEF        = 13,
   parameter int GUARD        = 12,
   parameter int TIMEOUT      = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       vad,
   input  logic       mfcc_means_valid,
   input  logic       match_ready,
   output logic       seg_active,
   output logic [9:0] seg_frames,
   output logic [3:0] coef_idx,
   output logic       coef_vld,
   output logic       seg_done,
   output logic       seg_abort,
   output logic       busy
);
   localparam int OW = $clog2(ONSET_FRAMES + 1);
   localparam int HW = $clog2(HANG_FRAMES + 1);
   localparam int WMAX = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
   localparam int WW = $clog2(WMAX + 1);
   typedef enum logic [2:0] {S_IDLE, S_ONSET, S_ACTIVE, S_HANG, S_FLUSH, S_REPORT, S_GUARD} state_t;
   state_t state, state_n;
   logic [OW-1:0] on_cnt, on_n, on_inc;
   logic [HW-1:0] hang_cnt, hang_n;
   logic [WW-1:0] wait_cnt;
   logic [9:0] frames_n, sf_inc;
   logic [3:0] coef_cnt;
   logic abort_n, burst_end, accept;
   assign sf_inc = (seg_frames == 10'd1023) ? seg_frames : seg_frames + 10'd1;
   assign on_inc = on_cnt + OW'(1);
   assign burst_end = coef_vld && (coef_idx == 4'(NCOEF - 1));
   assign accept = (state == S_FLUSH) && mfcc_means_valid && (coef_cnt != 4'(NCOEF));
   always_comb begin
      state_n = state;
      on_n = on_cnt;
      hang_n = hang_cnt;
      frames_n = seg_frames;
      abort_n = 1'b0;
      case (state)
         S_IDLE:
            if (frame_tick && vad) begin
               on_n = OW'(1);
               state_n = (ONSET_FRAMES == 1) ? S_ACTIVE : S_ONSET;
               frames_n = (ONSET_FRAMES == 1) ? 10'd0 : seg_frames;
            end
         S_ONSET:
            if (frame_tick) begin
               on_n = vad ? on_inc : OW'(0);
               state_n = !vad ? S_IDLE : (on_inc == OW'(ONSET_FRAMES)) ? S_ACTIVE : S_ONSET;
               frames_n = (vad && on_inc == OW'(ONSET_FRAMES)) ? 10'd0 : seg_frames;
            end
         S_ACTIVE:
            if (frame_tick) begin
               frames_n = sf_inc;
               hang_n = HW'(1);
               state_n = (sf_inc >= 10'(MAX_FRAMES)) ? S_FLUSH : vad ? S_ACTIVE :
                         (HANG_FRAMES == 1) ? S_FLUSH : S_HANG;
            end
         S_HANG:
            if (frame_tick) begin
               frames_n = sf_inc;
               hang_n = vad ? HW'(0) : hang_cnt + HW'(1);
               state_n = (sf_inc >= 10'(MAX_FRAMES)) ? S_FLUSH : vad ? S_ACTIVE :
                         (hang_n == HW'(HANG_FRAMES)) ? S_FLUSH : S_HANG;
            end
         S_FLUSH:
            // a completing burst wins over a coincident timeout
            if (burst_end) begin
               state_n = (seg_frames >= 10'(MIN_FRAMES)) ? S_REPORT : S_GUARD;
               abort_n = (seg_frames < 10'(MIN_FRAMES));
            end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
               state_n = S_GUARD;
               abort_n = 1'b1;
            end
         S_REPORT: state_n = match_ready ? S_GUARD : S_REPORT;
         S_GUARD:  state_n = (wait_cnt == WW'(GUARD - 1)) ? S_IDLE : S_GUARD;
         default:  state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         on_cnt <= '0;
         hang_cnt <= '0;
         wait_cnt <= '0;
         seg_frames <= '0;
         coef_cnt <= '0;
         coef_idx <= '0;
         coef_vld <= 1'b0;
         seg_active <= 1'b0;
         seg_done <= 1'b0;
         seg_abort <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= state_n;
         on_cnt <= on_n;
         hang_cnt <= hang_n;
         wait_cnt <= (state_n != state) ? '0 : wait_cnt + WW'(1);
         seg_frames <= frames_n;
         coef_cnt <= (state_n == S_FLUSH && state != S_FLUSH) ? 4'd0 : accept ? coef_cnt + 4'd1 : coef_cnt;
         coef_idx <= (state_n == S_FLUSH && state != S_FLUSH) ? 4'd0 : accept ? coef_cnt : coef_idx;
         coef_vld <= accept;
         seg_active <= (state_n == S_ACTIVE) || (state_n == S_HANG);
         seg_done <= (state_n == S_REPORT);
         seg_abort <= abort_n;
         busy <= (state_n != S_IDLE);
      end
   end
endmodule

// File: tb/tb_mfcc_seg_ctrl.sv
// tb_mfcc_seg_ctrl: directed segment scenarios with hand-computed expectations
module tb_mfcc_seg_ctrl;
   logic clk = 1'b0, rst_n = 1'b0;
   logic frame_tick = 1'b0, vad = 1'b0, mfcc_means_valid = 1'b0, match_ready = 1'b0;
   logic seg_active, coef_vld, seg_done, seg_abort, busy;
   logic [9:0] seg_frames;
   logic [3:0] coef_idx;
   int total = 0, bad = 0;

   mfcc_seg_ctrl dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .vad(vad),
      .mfcc_means_valid(mfcc_means_valid), .match_ready(match_ready),
      .seg_active(seg_active), .seg_frames(seg_frames), .coef_idx(coef_idx),
      .coef_vld(coef_vld), .seg_done(seg_done), .seg_abort(seg_abort), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic v);
      @(negedge clk);
      frame_tick = 1'b1;
      vad = v;
      @(negedge clk);
      frame_tick = 1'b0;
      vad = 1'b0;
   endtask

   task automatic ticks(input int n, input logic v);
      for (int i = 0; i < n; i++) tick(v);
   endtask

   task automatic burst(input int n);
      for (int i = 0; i < n; i++) begin
         mfcc_means_valid = 1'b1;
         @(negedge clk);
         chk("coef_vld", int'(coef_vld), 1);
         chk("coef_idx", int'(coef_idx), i);
      end
      mfcc_means_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 && busy; i++) @(negedge clk);
      chk("idle", int'(busy), 0);
   endtask

   initial begin
      #12;
      chk("rst_active", int'(seg_active), 0);
      chk("rst_frames", int'(seg_frames), 0);
      chk("rst_vld", int'(coef_vld), 0);
      chk("rst_idx", int'(coef_idx), 0);
      chk("rst_done", int'(seg_done), 0);
      chk("rst_abort", int'(seg_abort), 0);
      chk("rst_busy", int'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      // onset reject
      tick(1'b1);
      tick(1'b1);
      chk("onset_busy", int'(busy), 1);
      chk("onset_active", int'(seg_active), 0);
      tick(1'b0);
      chk("reject_busy", int'(busy), 0);
      chk("reject_active", int'(seg_active), 0);
      // nominal segment: 40 voiced + 8 hang frames
      ticks(2, 1'b1);
      chk("pre_open", int'(seg_active), 0);
      tick(1'b1);
      chk("open", int'(seg_active), 1);
      ticks(40, 1'b1);
      ticks(7, 1'b0);
      chk("hang7", int'(seg_active), 1);
      tick(1'b0);
      chk("closed", int'(seg_active), 0);
      chk("nom_frames", int'(seg_frames), 48);
      burst(13);
      chk("nom_done", int'(seg_done), 1);
      chk("nom_noabort", int'(seg_abort), 0);
      repeat (3) @(negedge clk);
      chk("done_held", int'(seg_done), 1);
      chk("frames_held", int'(seg_frames), 48);
      match_ready = 1'b1;
      @(negedge clk);
      match_ready = 1'b0;
      chk("done_clr", int'(seg_done), 0);
      chk("guard_busy", int'(busy), 1);
      repeat (11) @(negedge clk);
      chk("guard_end_busy", int'(busy), 1);
      @(negedge clk);
      chk("guard_idle", int'(busy), 0);
      // hang bridge
      ticks(3, 1'b1);
      ticks(10, 1'b1);
      ticks(5, 1'b0);
      chk("bridge_hang5", int'(seg_active), 1);
      ticks(10, 1'b1);
      ticks(7, 1'b0);
      chk("bridge_hang7", int'(seg_active), 1);
      tick(1'b0);
      chk("bridge_closed", int'(seg_active), 0);
      chk("bridge_frames", int'(seg_frames), 33);
      burst(13);
      chk("bridge_done", int'(seg_done), 1);
      match_ready = 1'b1;
      @(negedge clk);
      match_ready = 1'b0;
      chk("bridge_done_clr", int'(seg_done), 0);
      wait_idle();
      // short segment
      ticks(5, 1'b1);
      ticks(8, 1'b0);
      chk("short_frames", int'(seg_frames), 10);
      burst(13);
      chk("short_abort", int'(seg_abort), 1);
      chk("short_nodone", int'(seg_done), 0);
      @(negedge clk);
      chk("short_abort_pulse", int'(seg_abort), 0);
      chk("short_nodone2", int'(seg_done), 0);
      wait_idle();
      // forced close at MAX_FRAMES, match_ready already high
      match_ready = 1'b1;
      ticks(3, 1'b1);
      ticks(999, 1'b1);
      chk("max_999", int'(seg_active), 1);
      chk("max_999_frames", int'(seg_frames), 999);
      tick(1'b1);
      chk("max_closed", int'(seg_active), 0);
      chk("max_frames", int'(seg_frames), 1000);
      burst(13);
      chk("max_done", int'(seg_done), 1);
      @(negedge clk);
      chk("max_done_1cyc", int'(seg_done), 0);
      match_ready = 1'b0;
      wait_idle();
      // flush timeout
      ticks(5, 1'b1);
      ticks(8, 1'b0);
      repeat (254) @(negedge clk);
      chk("to_254", int'(seg_abort), 0);
      @(negedge clk);
      chk("to_255", int'(seg_abort), 1);
      @(negedge clk);
      chk("to_pulse", int'(seg_abort), 0);
      chk("to_guard", int'(busy), 1);
      chk("to_nodone", int'(seg_done), 0);
      wait_idle();
      // async reset in HANG
      ticks(8, 1'b1);
      ticks(2, 1'b0);
      chk("hang_active", int'(seg_active), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_hang_active", int'(seg_active), 0);
      chk("ar_hang_busy", int'(busy), 0);
      chk("ar_hang_frames", int'(seg_frames), 0);
      @(negedge clk);
      rst_n = 1'b1;
      ticks(2, 1'b1);
      chk("re_onset2", int'(seg_active), 0);
      tick(1'b1);
      chk("re_onset3", int'(seg_active), 1);
      // async reset in REPORT
      ticks(20, 1'b1);
      ticks(8, 1'b0);
      chk("rep_frames", int'(seg_frames), 28);
      burst(13);
      chk("rep_done", int'(seg_done), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_rep_done", int'(seg_done), 0);
      chk("ar_rep_busy", int'(busy), 0);
      chk("ar_rep_idx", int'(coef_idx), 0);
      @(negedge clk);
      rst_n = 1'b1;
      ticks(3, 1'b1);
      chk("final_open", int'(seg_active), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
